// File: rtl/echo_fb_mc.sv
// Multi-channel regenerative echo over one time-multiplexed sync-read RAM.
// Cleared after reset; processes channels in RD/MX/WR steps per sample.
`timescale 1ns/1ps
module echo_fb_mc #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_BITS    = 15,
    parameter int NUM_CH       = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           new_sample_ready,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] in_samples,
    input  logic                           echo_enable,
    input  logic                           feedback_enable,
    input  logic [ADDR_BITS-1:0]           delay_samples,
    input  logic [2:0]                     atten_shift,
    input  logic [2:0]                     fb_shift,
    output logic [NUM_CH*SAMPLE_WIDTH-1:0] out_samples,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           overrun
);
    localparam int SW    = SAMPLE_WIDTH;
    localparam int CB    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = ADDR_BITS + CB;
    localparam int DEPTH = NUM_CH << ADDR_BITS;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RD,
        S_MX,
        S_WR
    } state_t;

    state_t                 r_state;
    logic [AW-1:0]          r_clr;
    logic [ADDR_BITS-1:0]   r_ptr;
    logic [ADDR_BITS-1:0]   r_delay;
    logic [CB-1:0]          r_ch;
    logic [NUM_CH*SW-1:0]   r_dry;
    logic [NUM_CH*SW-1:0]   r_stage;
    logic [NUM_CH*SW-1:0]   r_out;
    logic                   r_echo;
    logic                   r_fb;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_overrun;
    logic [2:0]             r_atten;
    logic [2:0]             r_fbsh;
    logic [SW-1:0]          r_wb;
    logic [SW-1:0]          r_q;
    logic [SW-1:0]          r_mem [DEPTH];

    logic signed [SW-1:0]   w_dry;
    logic signed [SW-1:0]   w_wet;
    logic signed [SW-1:0]   w_wet_o;
    logic signed [SW-1:0]   w_wet_f;
    logic [SW:0]            w_sum_o;
    logic [SW:0]            w_sum_f;
    logic [ADDR_BITS-1:0]   w_rptr;
    logic                   w_we;
    logic                   w_re;
    logic [AW-1:0]          w_waddr;
    logic [AW-1:0]          w_raddr;
    logic [SW-1:0]          w_wdata;

    function automatic logic [SW-1:0] f_sat(input logic [SW:0] v);
        logic [SW-1:0] r;
        if (v[SW] != v[SW-1])
            r = v[SW] ? {1'b1, {(SW-1){1'b0}}}
                      : {1'b0, {(SW-1){1'b1}}};
        else
            r = v[SW-1:0];
        return r;
    endfunction

    always_comb begin
        w_dry   = r_dry[int'(r_ch)*SW +: SW];
        w_wet   = r_q;
        w_wet_o = w_wet >>> r_atten;
        w_wet_f = w_wet >>> r_fbsh;
        w_sum_o = {w_dry[SW-1], w_dry}
                + (r_echo ? {w_wet_o[SW-1], w_wet_o}
                          : {(SW+1){1'b0}});
        w_sum_f = {w_dry[SW-1], w_dry}
                + ((r_echo && r_fb) ? {w_wet_f[SW-1], w_wet_f}
                                    : {(SW+1){1'b0}});
        w_rptr  = r_ptr - r_delay;
        w_re    = (r_state == S_RD);
        w_raddr = {r_ch, w_rptr};
        w_we    = (r_state == S_CLEAR) || (r_state == S_WR);
        w_waddr = (r_state == S_CLEAR) ? r_clr : {r_ch, r_ptr};
        w_wdata = (r_state == S_CLEAR) ? '0 : r_wb;
    end

    // Delay RAM carries no reset; CLEAR zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        if (w_re)
            r_q <= r_mem[w_raddr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_CLEAR;
            r_clr     <= '0;
            r_ptr     <= '0;
            r_delay   <= '0;
            r_ch      <= '0;
            r_dry     <= '0;
            r_stage   <= '0;
            r_out     <= '0;
            r_echo    <= 1'b0;
            r_fb      <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b1;
            r_overrun <= 1'b0;
            r_atten   <= '0;
            r_fbsh    <= '0;
            r_wb      <= '0;
        end else begin
            r_valid <= 1'b0;
            if (new_sample_ready && r_state != S_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                S_CLEAR: begin
                    r_clr <= r_clr + 1'b1;
                    if (r_clr == AW'(DEPTH - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (new_sample_ready) begin
                        r_dry   <= in_samples;
                        r_echo  <= echo_enable;
                        r_fb    <= feedback_enable;
                        r_delay <= delay_samples;
                        r_atten <= atten_shift;
                        r_fbsh  <= fb_shift;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RD;
                    end
                end
                S_RD: r_state <= S_MX;
                S_MX: begin
                    r_stage[int'(r_ch)*SW +: SW] <= f_sat(w_sum_o);
                    r_wb    <= f_sat(w_sum_f);
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (r_ch == CB'(NUM_CH - 1)) begin
                        r_ptr   <= r_ptr + 1'b1;
                        r_out   <= r_stage;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= S_RD;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_clr   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign out_samples = r_out;
    assign out_valid   = r_valid;
    assign busy        = r_busy;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_echo_fb_mc.sv
// Bench for echo_fb_mc: per-channel delay-line model plus pinned literals.
// Every out_valid pulse is checked for timing and value against the model.
`timescale 1ns/1ps
module tb_echo_fb_mc;
    localparam int SW = 16;
    localparam int AB = 4;
    localparam int NC = 2;
    localparam int DL = 1 << AB;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            nsr = 1'b0;
    logic [NC*SW-1:0] in_samples = '0;
    logic            echo_enable = 1'b0;
    logic            feedback_enable = 1'b0;
    logic [AB-1:0]   delay_samples = '0;
    logic [2:0]      atten_shift = '0;
    logic [2:0]      fb_shift = '0;
    logic [NC*SW-1:0] out_samples;
    logic            out_valid;
    logic            busy;
    logic            overrun;

    echo_fb_mc #(
        .SAMPLE_WIDTH(SW),
        .ADDR_BITS(AB),
        .NUM_CH(NC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .new_sample_ready(nsr),
        .in_samples(in_samples),
        .echo_enable(echo_enable),
        .feedback_enable(feedback_enable),
        .delay_samples(delay_samples),
        .atten_shift(atten_shift),
        .fb_shift(fb_shift),
        .out_samples(out_samples),
        .out_valid(out_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name,
                       input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: one circular delay line per channel, in plain integers.
    typedef struct {
        int cyc;
        int v0;
        int v1;
    } exp_t;

    int   mline [NC][DL];
    int   mptr = 0;
    exp_t q[$];

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < DL; i++)
                mline[c][i] = 0;
        mptr = 0;
        q.delete();
    endtask

    task automatic mpush(input int s0, input int s1,
                         input bit e, input bit f,
                         input int d, input int a, input int fs);
        int   s [NC];
        int   o [NC];
        int   wb [NC];
        int   wet;
        exp_t x;
        s[0] = s0;
        s[1] = s1;
        for (int c = 0; c < NC; c++) begin
            wet   = mline[c][(mptr - d) & (DL - 1)];
            o[c]  = sat(s[c] + (e ? (wet >>> a) : 0));
            wb[c] = sat(s[c] + ((e && f) ? (wet >>> fs) : 0));
        end
        for (int c = 0; c < NC; c++)
            mline[c][mptr] = wb[c];
        mptr  = (mptr + 1) & (DL - 1);
        x.cyc = cyc + 3 * NC;
        x.v0  = o[0];
        x.v1  = o[1];
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("out_ch0", $signed(out_samples[SW-1:0]), e.v0);
                chk("out_ch1", $signed(out_samples[2*SW-1:SW]), e.v1);
            end
        end else if (q.size() > 0 && cyc > q[0].cyc) begin
            chk("missing_valid", 0, 1);
            void'(q.pop_front());
        end
    end

    // Strobe sampled at the second edge; config is scrambled afterwards.
    task automatic kick(input int s0, input int s1,
                        input bit e, input bit f,
                        input int d, input int a, input int fs);
        @(posedge clk);
        #1;
        in_samples      = {SW'(s1), SW'(s0)};
        echo_enable     = e;
        feedback_enable = f;
        delay_samples   = AB'(d);
        atten_shift     = 3'(a);
        fb_shift        = 3'(fs);
        nsr = 1'b1;
        @(posedge clk);
        #1;
        nsr = 1'b0;
        in_samples      = 32'hDEAD_BEEF;
        echo_enable     = !e;
        feedback_enable = !f;
        delay_samples   = AB'(d + 5);
        atten_shift     = 3'(a + 3);
        fb_shift        = 3'(fs + 2);
    endtask

    task automatic send(input int s0, input int s1,
                        input bit e, input bit f,
                        input int d, input int a, input int fs,
                        input bit pin, input int p0, input int p1);
        kick(s0, s1, e, f, d, a, fs);
        mpush(s0, s1, e, f, d, a, fs);
        repeat (5) @(posedge clk);
        if (pin) begin
            @(posedge clk);
            @(negedge clk);
            chk("pin_ch0", $signed(out_samples[SW-1:0]), p0);
            chk("pin_ch1", $signed(out_samples[2*SW-1:SW]), p1);
        end
    endtask

    task automatic poke(input int k);
        repeat (k) @(posedge clk);
        #1;
        in_samples = 32'h1234_4321;
        nsr = 1'b1;
        @(posedge clk);
        #1;
        nsr = 1'b0;
    endtask

    task automatic do_reset(input bit poke_clear);
        int n;
        reset_n = 1'b0;
        #1;
        chk("rst_out", out_samples, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 1);
        chk("rst_overrun", overrun, 0);
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (poke_clear) nsr = (n == 5);
        end while (busy === 1'b1 && n < 100);
        nsr = 1'b0;
        chk("clear_len", n, 32);
        chk("post_clr_overrun", overrun, poke_clear);
        chk("post_clr_out", out_samples, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        do_reset(1'b1);
        repeat (4) @(posedge clk);
        chk("t1_no_valid_q", q.size(), 0);

        // Plain echo, no feedback
        @(posedge clk); #1; do_reset(1'b0);
        for (int n = 0; n < 9; n++)
            send(n == 0 ? 1000 : 0, 0, 1, 0, 3, 1, 0,
                 n == 0 || n == 3, n == 0 ? 1000 : 500, 0);

        // Feedback halving every 3 samples
        @(posedge clk); #1; do_reset(1'b0);
        for (int n = 0; n < 13; n++)
            send(n == 0 ? 1000 : 0, 0, 1, 1, 3, 0, 1,
                 (n % 3) == 0, 1000 >> ((n < 3) ? 0 : n / 3 - 1), 0);

        // Saturation both ways on ch1
        @(posedge clk); #1; do_reset(1'b0);
        for (int n = 0; n < 8; n++)
            send(100, n < 4 ? 30000 : -30000, 1, 0, 1, 0, 0,
                 n == 2 || n == 5, 200, n == 2 ? 32767 : -32768);

        // delay 0 wraps the full line; max-rate strobes
        @(posedge clk); #1; do_reset(1'b0);
        for (int n = 0; n < 18; n++)
            send(n == 0 ? 77 : 0, 0, 1, 0, 0, 0, 0,
                 n == 0 || n == 16, n == 0 ? 77 : 77, 0);
        chk("t5_no_overrun", overrun, 0);
        kick(5, 6, 1, 0, 0, 0, 0);
        mpush(5, 6, 1, 0, 0, 0, 0);
        poke(2);
        repeat (6) @(posedge clk);
        chk("t5_overrun", overrun, 1);
        send(-8, 9, 1, 0, 0, 0, 0, 1'b0, 0, 0);

        // Strobe on the final WR edge is an overrun
        @(posedge clk); #1; do_reset(1'b0);
        kick(11, -22, 1, 0, 2, 0, 0);
        mpush(11, -22, 1, 0, 2, 0, 0);
        poke(5);
        repeat (4) @(posedge clk);
        chk("wr_edge_overrun", overrun, 1);

        // Reset mid RD of ch1 aborts and wipes old echo
        @(posedge clk); #1; do_reset(1'b0);
        send(500, 0, 1, 0, 2, 0, 0, 1'b1, 500, 0);
        kick(0, 0, 1, 0, 2, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        do_reset(1'b0);
        for (int n = 0; n < 3; n++)
            send(0, 0, 1, 0, 2, 0, 0, n == 2, 0, 0);

        repeat (10) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
